// File: rtl/load_store_unit.sv
// MIPS load/store unit: memory-interface initiator with read-modify-write sub-word stores.
// Define LSU_SUBWORD_EN to enable byte/halfword accesses; otherwise only LW/SW are legal.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              startF,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] byteAddress,
    input  logic [31:0]       storeData,
    output logic              busyF,
    output logic              doneF,
    output logic              errF,
    output logic [31:0]       loadData,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteData,
    output logic              memWriteF,
    output logic              memReadF,
    input  logic [31:0]       memReadData
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [31:0]       load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LSU_SUBWORD_EN
    logic [5:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       sdata_q, sdata_d;
`endif

    function automatic logic req_error(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:          return off != 2'b00;
`ifdef LSU_SUBWORD_EN
            OP_LH, OP_LHU, OP_SH:  return off[0];
            OP_LB, OP_LBU, OP_SB:  return 1'b0;
`endif
            default:               return 1'b1;
        endcase
    endfunction

`ifdef LSU_SUBWORD_EN
    // Big-endian lanes: offset 0 is the most significant byte/halfword.
    function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*(3-int'(off)) +: 8];
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [5:0] op, input logic [1:0] off,
                                          input logic [31:0] word, input logic [15:0] sd);
        logic [31:0] w;
        w = word;
        if (op == OP_SB) w[8*(3-int'(off)) +: 8] = sd[7:0];
        else if (off[1]) w[15:0] = sd;
        else             w[31:16] = sd;
        return w;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load_d  = load_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LSU_SUBWORD_EN
        op_d    = op_q;
        off_d   = off_q;
        sdata_d = sdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (startF) begin
`ifdef LSU_SUBWORD_EN
                    op_d    = opcode;
                    off_d   = byteAddress[1:0];
                    sdata_d = storeData[15:0];
`endif
                    err_d = req_error(opcode, byteAddress[1:0]);
                    if (err_d) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = {2'b00, byteAddress[ADDR_W-1:2]};
                        if (opcode == OP_SW) begin
                            wdata_d = storeData;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
`ifdef LSU_SUBWORD_EN
                if (op_q == OP_SB || op_q == OP_SH) begin
                    wdata_d = merge(op_q, off_q, memReadData, sdata_q);
                    state_d = S_WRITE;
                end else begin
                    load_d  = extract(op_q, off_q, memReadData);
                    state_d = S_DONE;
                end
`else
                load_d  = memReadData;
                state_d = S_DONE;
`endif
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            load_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LSU_SUBWORD_EN
            op_q    <= '0;
            off_q   <= '0;
            sdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LSU_SUBWORD_EN
            op_q    <= op_d;
            off_q   <= off_d;
            sdata_q <= sdata_d;
`endif
        end
    end

    assign busyF        = (state_q != S_IDLE);
    assign doneF        = (state_q == S_DONE);
    assign errF         = err_q;
    assign loadData     = load_q;
    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;
    assign memReadF     = (state_q == S_READ);
    assign memWriteF    = (state_q == S_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        startF = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] byteAddress = '0;
    logic [31:0] storeData = '0;
    logic        busyF, doneF, errF, memWriteF, memReadF;
    logic [31:0] loadData, memAddress, memWriteData;
    logic [31:0] memReadData = '0;
    logic [31:0] mem [0:15];

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .startF(startF), .opcode(opcode),
        .byteAddress(byteAddress), .storeData(storeData), .busyF(busyF),
        .doneF(doneF), .errF(errF), .loadData(loadData), .memAddress(memAddress),
        .memWriteData(memWriteData), .memWriteF(memWriteF), .memReadF(memReadF),
        .memReadData(memReadData)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (memWriteF) mem[memAddress[3:0]] <= memWriteData;
        if (memReadF)  memReadData <= mem[memAddress[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},  {31'h0, busyF},     0);
        chk({tag, "_done"},  {31'h0, doneF},     0);
        chk({tag, "_err"},   {31'h0, errF},      0);
        chk({tag, "_rd"},    {31'h0, memReadF},  0);
        chk({tag, "_wr"},    {31'h0, memWriteF}, 0);
        chk({tag, "_load"},  loadData,           0);
        chk({tag, "_addr"},  memAddress,         0);
        chk({tag, "_wdata"}, memWriteData,       0);
    endtask

    // e_rd/e_wr: cycle after accept of the read/write strobe, 0 = never.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] ba,
                          input logic [31:0] sd, input bit hold, input int e_lat,
                          input int e_rd, input int e_wr, input bit e_err,
                          input logic [31:0] e_load, input logic [31:0] e_wdata,
                          input logic [31:0] e_addr);
        int rd = 0, wr = 0, lat = 0, both = 0;
        logic        err_s = 1'b0;
        logic [31:0] load_s = '0, rd_addr = '0, wr_addr = '0, wr_data = '0;
        @(negedge clock);
        startF = 1'b1; opcode = op; byteAddress = ba; storeData = sd;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clock);
            if (!hold) startF = 1'b0;
            if (memReadF && memWriteF) both++;
            if (memReadF && rd == 0) begin rd = k; rd_addr = memAddress; end
            if (memWriteF && wr == 0) begin wr = k; wr_addr = memAddress; wr_data = memWriteData; end
            if (doneF) begin lat = k; err_s = errF; load_s = loadData; end
        end
        startF = 1'b0;
        chk({tag, "_lat"},  lat, e_lat);
        chk({tag, "_err"},  {31'h0, err_s}, {31'h0, e_err});
        chk({tag, "_rdcyc"}, rd, e_rd);
        chk({tag, "_wrcyc"}, wr, e_wr);
        chk({tag, "_rwx"},  both, 0);
        if (e_rd != 0) chk({tag, "_rdaddr"}, rd_addr, e_addr);
        if (e_rd != 0 && e_wr == 0) chk({tag, "_load"}, load_s, e_load);
        if (e_wr != 0) begin
            chk({tag, "_wraddr"}, wr_addr, e_addr);
            chk({tag, "_wdata"},  wr_data, e_wdata);
        end
        if (hold) begin
            @(negedge clock);
            chk({tag, "_nobusy"}, {31'h0, busyF}, 0);
        end
    endtask

    task automatic reset_mid(input string tag, input logic [5:0] op, input logic [31:0] ba,
                             input logic [31:0] sd, input int at_k);
        int wcnt = 0;
        @(negedge clock);
        startF = 1'b1; opcode = op; byteAddress = ba; storeData = sd;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clock);
            startF = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle_zero(tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (memWriteF) wcnt++;
        end
        chk({tag, "_nowrite"}, wcnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5] = 32'h8899AABB;
        mem[2] = 32'h11223344;
        repeat (3) @(negedge clock);
        check_idle_zero("rst");
        reset = 1'b0;
        @(negedge clock);

        run_op("lw14", 6'h23, 32'h14, 0, 0, 3, 1, 0, 0, 32'h8899AABB, 0, 5);
        run_op("lb15", 6'h20, 32'h15, 0, 0, SUB ? 3 : 1, SUB ? 1 : 0, 0, !SUB,
               32'hFFFFFF99, 0, 5);
        run_op("lbu15", 6'h24, 32'h15, 0, 0, SUB ? 3 : 1, SUB ? 1 : 0, 0, !SUB,
               32'h00000099, 0, 5);
        run_op("lhu16", 6'h25, 32'h16, 0, 0, SUB ? 3 : 1, SUB ? 1 : 0, 0, !SUB,
               32'h0000AABB, 0, 5);
        run_op("lh14", 6'h21, 32'h14, 0, 0, SUB ? 3 : 1, SUB ? 1 : 0, 0, !SUB,
               32'hFFFF8899, 0, 5);
        run_op("sb0b", 6'h28, 32'h0B, 32'hFFFFFF77, 0, SUB ? 4 : 1, SUB ? 1 : 0,
               SUB ? 3 : 0, !SUB, 0, 32'h11223377, 2);
        chk("mem2", mem[2], SUB ? 32'h11223377 : 32'h11223344);
        run_op("sw14", 6'h2B, 32'h14, 32'd1000, 0, 2, 0, 1, 0, 0, 32'h000003E8, 5);
        run_op("lw14b", 6'h23, 32'h14, 0, 0, 3, 1, 0, 0, 32'h000003E8, 0, 5);
        run_op("lw16", 6'h23, 32'h16, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_op("lh13", 6'h21, 32'h13, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_op("op3f", 6'h3F, 32'h14, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        chk("errhold", {31'h0, errF}, 1);
        run_op("lw08", 6'h23, 32'h08, 0, 1, 3, 1, 0, 0,
               SUB ? 32'h11223377 : 32'h11223344, 0, 2);
        if (SUB) reset_mid("rst_sh", 6'h29, 32'h14, 32'h0000ABCD, 2);
        else     reset_mid("rst_lw", 6'h23, 32'h14, 0, 1);
        chk("mem5", mem[5], 32'h000003E8);
        run_op("lw14c", 6'h23, 32'h14, 0, 0, 3, 1, 0, 0, 32'h000003E8, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MIPS load/store unit that acts as the initiator side of the data-memory interface. It accepts one load or store request at a time from the MEM pipeline stage and drives word address, write data and read/write strobes to `Data_Memory`. It then returns aligned, sign- or zero-extended load data. Sub-word stores are performed as read-modify-write sequences.

## Interface
Parameters:
- `ADDR_W`, 32: width of the byte address and of the memory word address.

Ports:
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high; sampled on the `clock` rising edge.
- `startF`  in  1  request strobe; accepted only in IDLE.
- `opcode`  in  6  MIPS primary opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- `byteAddress`  in  ADDR_W  effective byte address.
- `storeData`  in  32  store source (rt); the low byte or halfword is used for SB/SH.
- `busyF`  out  1  high in every state except IDLE.
- `doneF`  out  1  one-cycle completion pulse.
- `errF`  out  1  valid with `doneF`; set for a misaligned or illegal request.
- `loadData`  out  32  extended load result; valid from `doneF` until the next accepted request.
- `memAddress`  out  ADDR_W  word address, equal to `byteAddress >> 2`.
- `memWriteData`  out  32  word written to memory.
- `memWriteF`  out  1  write strobe; memory commits on the rising edge that ends the cycle.
- `memReadF`  out  1  read strobe; `memReadData` is valid exactly one cycle later.
- `memReadData`  in  32  word returned by memory.

## Operation
- Byte order is big-endian: byte offset 0 maps to bits [31:24], and halfword offset 0 maps to bits [31:16].
- IDLE: on `startF`, latch the opcode, the word address, the byte offset `byteAddress[1:0]` and `storeData`.
  - Misaligned or illegal requests go to DONE with `errF=1`. Misaligned means a halfword with offset bit0 set, or a word with a nonzero offset. Illegal means an opcode not in the list.
  - Errored requests make no memory access.
  - Loads and SB/SH go to READ; SW goes to WRITE.
- READ: `memReadF=1`. Next state is CAPTURE.
- CAPTURE: sample `memReadData`.
  - Loads: extract the addressed lane into `loadData`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word. Next state is DONE.
  - SB/SH: merge the low byte or halfword of latched `storeData` into the addressed lane, keeping all other lanes. Next state is WRITE.
- WRITE: `memWriteF=1`; `memWriteData` is the full word (SW) or the merged word. Next state is DONE.
- DONE: `doneF=1`. Next state is IDLE.
- `startF` outside IDLE is ignored; it is neither queued nor dropped with an error.
- `memAddress` and `memWriteData` hold their last values when the strobes are low.
- `memReadF` and `memWriteF` are never high in the same cycle.

## Timing
- Reset values: state IDLE; `busyF`, `doneF`, `errF`, `memReadF`, `memWriteF` = 0; `loadData`, `memAddress`, `memWriteData` = 0.
- Latency from the `startF` cycle N:
  - Load: READ at N+1, CAPTURE at N+2, `doneF` at N+3.
  - SW: WRITE at N+1, `doneF` at N+2.
  - SB/SH: `doneF` at N+4.
  - Error: `doneF` and `errF` at N+1.
- Back-to-back requests: the earliest next accept is the cycle after DONE, since the unit is back in IDLE.
- `errF` clears on the next accepted request or on reset.
- Reset mid-operation: the next state is IDLE with all outputs at their reset values.
  - If reset is asserted during a WRITE cycle, memory still commits on that edge.
  - If reset is asserted during a READ cycle, there is no side effect.
- Arithmetic: `memAddress = {2'b00, byteAddress[ADDR_W-1:2]}`. Offset wrap is not possible because an access never crosses a word.

## Configuration
- `LSU_SUBWORD_EN` defined: full behaviour as specified above.
- `LSU_SUBWORD_EN` undefined:
  - Only LW and SW are legal.
  - LB, LH, LBU, LHU, SB and SH take the error path: `doneF` at N+1 with `errF=1` and no memory access.
  - The CAPTURE merge and extract logic is removed.

## Test plan
- Memory word 5 = 0x8899AABB; LW at byte address 0x14 -> `memReadF` at N+1 with `memAddress=5`; `doneF` at N+3 with `loadData=0x8899AABB`, `errF=0`.
- Same word; LB at address 0x15 -> `loadData=0xFFFFFF99`; LBU at 0x15 -> `loadData=0x00000099`; LHU at 0x16 -> `loadData=0x0000AABB`.
- Word 2 = 0x11223344; SB at address 0x0B with `storeData=0xFFFFFF77` -> READ then WRITE with `memWriteData=0x11223377`; `doneF` at N+4.
- SW at address 0x14 with `storeData=1000` -> `memWriteF` at N+1 with `memAddress=5`, `memWriteData=0x000003E8`; a following LW at 0x14 returns 0x000003E8.
- LW at address 0x16 and LH at address 0x13 -> `doneF` and `errF` at N+1; `memReadF` and `memWriteF` never asserted. Opcode 0x3F gives the same result.
- Assert `reset` during the CAPTURE cycle of an SH -> IDLE next cycle, all outputs 0, no `memWriteF`. Also check that `startF` held high while busy starts no second request.
